// File: rtl/apb_timer_bridge.sv
// APB3 completer that bridges processor transfers onto the timer's native
// 8-bit register bus. It inserts a fixed number of wait states and rejects
// unmapped or misaligned accesses with PSLVERR, without touching the timer.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer in flight; a setup phase is latched here
// ACCESS | wait states count down; completes when counter hits zero
// DONE   | reserved, never entered in normal use; falls back to IDLE
module apb_timer_bridge #(
  parameter int ADDR_W      = 12,
  parameter int ADDR_LSB    = 2,
  parameter int NUM_REGS    = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_wren,
  output logic [7:0]        o_addr,
  output logic [7:0]        o_datain,
  input  logic [7:0]        i_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Byte-offset mask below the register index; works for ADDR_LSB of 0 too.
  localparam logic [ADDR_W-1:0] LSB_MASK   = ADDR_W'((1 << ADDR_LSB) - 1);
  localparam logic [4:0]        NUM_REGS_L = 5'(NUM_REGS);
  localparam logic [2:0]        WAIT_INIT  = 3'(WAIT_STATES);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wait_cnt;
  logic       wr_q;
  logic       err_q;

  logic [3:0] idx;
  logic       misaligned;
  logic       unmapped;
  logic       setup;
  logic       complete;

  // High write-data bits and address bits above the index are don't-care.
  logic       unused_bits;
  assign unused_bits = ^{i_pwdata[31:8], i_paddr};

  assign idx        = i_paddr[ADDR_LSB+3:ADDR_LSB];
  assign misaligned = (i_paddr & LSB_MASK) != '0;
  assign unmapped   = {1'b0, idx} >= NUM_REGS_L;
  assign setup      = i_psel & ~i_penable;
  assign complete   = (state == ST_ACCESS) & i_psel & i_penable & (wait_cnt == 3'd0);

  // State register.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dropped PSEL in ACCESS aborts the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (setup) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!i_psel || complete) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the transfer at setup and count down wait states in ACCESS.
  // o_addr/o_datain only move at setup so the timer read-back stays stable.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= 3'd0;
      o_addr   <= 8'h00;
      o_datain <= 8'h00;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if ((state == ST_IDLE) && setup) begin
      wait_cnt <= WAIT_INIT;
      o_addr   <= {4'h0, idx};
      o_datain <= i_pwdata[7:0];
      wr_q     <= i_pwrite;
      err_q    <= misaligned | unmapped;
    end else if ((state == ST_ACCESS) && i_psel && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Response decode: everything is zero outside the completion cycle, and an
  // erroring transfer never reaches the timer or returns its data.
  always_comb begin
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    o_wren    = 1'b0;
    o_prdata  = 32'h0;
    if (complete) begin
      o_pready  = 1'b1;
      o_pslverr = err_q;
      o_wren    = wr_q & ~err_q;
      if (!wr_q && !err_q) begin
        o_prdata = {24'h0, i_rdata};
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_bridge.sv
// Bench for apb_timer_bridge: two instances (0 and 3 wait states) share one
// APB bus, each backed by a simple timer register stub. A transaction-level
// model predicts latency, error response, read data and write side effects.
module tb_apb_timer_bridge;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk_sys;
  logic        rst_n;
  logic        psel0;
  logic        psel1;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;
  logic        wren0, wren1;
  logic [7:0]  addr0, addr1;
  logic [7:0]  datain0, datain1;
  logic [7:0]  rdata0, rdata1;

  logic [7:0]  tmem0 [0:255];
  logic [7:0]  tmem1 [0:255];
  logic [7:0]  refm  [0:1][0:15];

  int n_cmp = 0;
  int n_err = 0;

  apb_timer_bridge #(.WAIT_STATES(WS0)) dut0 (
    .i_clk_sys(clk_sys), .i_rst_n(rst_n), .i_psel(psel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata0),
    .o_pready(pready0), .o_pslverr(pslverr0), .o_wren(wren0), .o_addr(addr0),
    .o_datain(datain0), .i_rdata(rdata0)
  );

  apb_timer_bridge #(.WAIT_STATES(WS1)) dut1 (
    .i_clk_sys(clk_sys), .i_rst_n(rst_n), .i_psel(psel1), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata1),
    .o_pready(pready1), .o_pslverr(pslverr1), .o_wren(wren1), .o_addr(addr1),
    .o_datain(datain1), .i_rdata(rdata1)
  );

  // Timer register stubs: combinational read, write on the wren pulse.
  assign rdata0 = tmem0[addr0];
  assign rdata1 = tmem1[addr1];

  always @(posedge clk_sys) begin
    if (wren0) tmem0[addr0] <= datain0;
    if (wren1) tmem1[addr1] <= datain1;
  end

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus idle for n cycles; both completers must stay silent.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      psel0 = 1'b0;
      psel1 = 1'b0;
      penable = 1'b0;
      #1;
      chk("idle_resp", {28'h0, pready0, pready1, wren0, wren1}, 32'h0);
      @(posedge clk_sys);
    end
  endtask

  // One APB transfer on completer d. abort_at >= 0 drops PSEL after that many
  // access cycles. Entered and left just after a rising edge, so two calls in a
  // row are back-to-back with no dead cycle.
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input int abort_at);
    int          ws, cyc, wren_cnt, idx;
    bit          err, done, aborted;
    logic        slverr_o;
    logic [31:0] rd_o;
    logic [7:0]  addr_o, din_o;
    logic [31:0] exp_rd;
    ws  = (d == 0) ? WS0 : WS1;
    idx = (int'(addr) / 4) % 16;
    err = (addr % 4 != 0) || (idx >= 12);
    done = 0; aborted = 0; wren_cnt = 0;
    slverr_o = 0; rd_o = 0; addr_o = 0; din_o = 0;

    @(negedge clk_sys);
    psel0 = (d == 0);
    psel1 = (d == 1);
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = wd;
    #1;
    chk("setup_pready", {31'h0, (d == 0) ? pready0 : pready1}, 32'h0);
    @(posedge clk_sys);
    cyc = 1;
    while (!done && !aborted && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
      if (abort_at >= 0 && cyc - 2 == abort_at) begin
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
        #1;
        chk("abort_resp", {30'h0, (d == 0) ? pready0 : pready1,
                           (d == 0) ? wren0 : wren1}, 32'h0);
        aborted = 1;
      end else begin
        penable = 1'b1;
        #1;
        if ((d == 0) ? wren0 : wren1) wren_cnt++;
        if ((d == 0) ? pready0 : pready1) begin
          done     = 1;
          slverr_o = (d == 0) ? pslverr0 : pslverr1;
          rd_o     = (d == 0) ? prdata0 : prdata1;
          addr_o   = (d == 0) ? addr0 : addr1;
          din_o    = (d == 0) ? datain0 : datain1;
        end
      end
      @(posedge clk_sys);
    end

    if (aborted) begin
      chk("abort_wren", wren_cnt, 0);
    end else begin
      exp_rd = (wr || err) ? 32'h0 : {24'h0, refm[d][idx]};
      chk($sformatf("latency_d%0d", d), cyc, 2 + ws);
      chk($sformatf("pslverr_%03h", addr), {31'h0, slverr_o}, {31'h0, err});
      chk($sformatf("wren_cnt_%03h", addr), wren_cnt, (wr && !err) ? 1 : 0);
      chk($sformatf("o_addr_%03h", addr), {24'h0, addr_o}, idx);
      if (!wr) chk($sformatf("prdata_%03h", addr), rd_o, exp_rd);
      if (wr && !err) begin
        chk("o_datain", {24'h0, din_o}, {24'h0, wd[7:0]});
        refm[d][idx] = wd[7:0];
      end
    end
  endtask

  initial begin
    int          d, idx, ab, gap;
    bit          wr;
    logic [11:0] a;
    rst_n = 1'b0;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_resp0", {pready0, pslverr0, wren0, 5'h0, addr0, datain0, 8'h0}, 32'h0);
    chk("rst_resp1", {pready1, pslverr1, wren1, 5'h0, addr1, datain1, 8'h0}, 32'h0);
    chk("rst_prdata", prdata0 | prdata1, 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);

    // Bring every timer register to a known value through the bridge.
    for (int r = 0; r < 12; r++) begin
      xfer(0, 1'b1, 12'(r * 4), 32'h0, -1);
      xfer(1, 1'b1, 12'(r * 4), 32'h0, -1);
    end
    idle(1);

    // Directed cases.
    xfer(0, 1'b1, 12'h008, 32'h0000_00A5, -1);
    idle(1);
    xfer(1, 1'b1, 12'h02C, 32'hFFFF_FF3C, -1);
    xfer(1, 1'b0, 12'h02C, 32'h0, -1);
    idle(1);
    xfer(0, 1'b1, 12'h030, 32'h0000_0055, -1);
    xfer(0, 1'b0, 12'h009, 32'h0, -1);
    xfer(1, 1'b0, 12'h030, 32'h0, -1);
    xfer(0, 1'b1, 12'h004, 32'h1234_565A, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);
    idle(1);
    xfer(1, 1'b1, 12'h010, 32'h0000_00C3, 2);
    xfer(1, 1'b0, 12'h010, 32'h0, -1);
    idle(1);

    // Reset in the middle of a write's access phase.
    @(negedge clk_sys);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h77;
    @(posedge clk_sys);
    @(negedge clk_sys);
    penable = 1'b1;
    @(posedge clk_sys);
    #2;
    chk("pre_rst_addr", {24'h0, addr1}, 32'h05);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp", {29'h0, wren1, pready1, pslverr1}, 32'h0);
    chk("mid_rst_addr", {24'h0, addr1}, 32'h0);
    psel1 = 1'b0; penable = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    idle(2);
    xfer(1, 1'b0, 12'h014, 32'h0, -1);
    idle(1);

    // Randomized traffic across both completers.
    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom % 2);
      wr = 1'($urandom % 2);
      if ($urandom % 4 == 0) begin
        a = 12'($urandom);
      end else begin
        idx = int'($urandom_range(11, 0));
        a = {6'($urandom), 4'(idx), 2'b00};
      end
      ab = ($urandom % 6 == 0) ? int'($urandom_range((d == 0) ? WS0 : WS1, 0)) : -1;
      xfer(d, wr, a, $urandom, ab);
      gap = int'($urandom % 3);
      if (gap > 0 || ab >= 0) idle(gap + 1);
    end

    // Final read-back of every register on both sides.
    for (int r = 0; r < 12; r++) begin
      xfer(0, 1'b0, 12'(r * 4), 32'h0, -1);
      xfer(1, 1'b0, 12'(r * 4), 32'h0, -1);
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
